ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage, directly upstream of the decode/control block.
- Owns the PC register and issues one-outstanding-request reads to instruction memory.
- Holds each returned 32-bit instruction, with its PC, in an output register until decode accepts it.
- Takes redirects (taken branch, jal, jalr) from execute and discards any in-flight stale fetch.

Parameters:
PC_WIDTH, 64, width of PC and memory address
INST_WIDTH, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  PC_WIDTH  fetch address, always 4-byte aligned
imem_rsp_valid  input  1  read data valid
imem_rdata  input  INST_WIDTH  returned instruction
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst  output  INST_WIDTH  instruction to decode
inst_pc  output  PC_WIDTH  PC of inst
redirect_valid  input  1  execute requests PC change
redirect_pc  input  PC_WIDTH  redirect target
misalign_err  output  1  one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
- Reset, asynchronous:
  - pc=RESET_PC, state=S_REQ, drop=0.
  - inst=0, inst_pc=0, inst_valid=0, misalign_err=0.
  - imem_req_valid=1 from the first cycle after rst deasserts.
- imem_addr = pc, combinationally. imem_req_valid = (state==S_REQ). inst_valid = (state==S_VALID).
- At most one request outstanding.
- imem_rsp_valid is ignored in every state except S_WAIT.
- S_REQ:
  - On imem_req_valid & imem_req_ready -> S_WAIT.
  - Otherwise hold; pc and imem_addr stay stable while unaccepted.
- S_WAIT:
  - On imem_rsp_valid with drop=1: discard data, clear drop, -> S_REQ.
  - On imem_rsp_valid with drop=0: inst<=imem_rdata, inst_pc<=pc, -> S_VALID.
  - Minimum latency request-accept to inst_valid: 1 cycle after rsp_valid.
- S_VALID:
  - inst and inst_pc held stable until inst_ready.
  - On inst_ready: pc<=pc+4, -> S_REQ.
  - pc+4 wraps modulo 2^PC_WIDTH; no fault.
- Redirect, highest priority, evaluated every cycle outside reset:
  - pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}.
  - misalign_err pulses 1 cycle if redirect_pc[1:0] != 0.
  - S_REQ, no handshake this cycle: stay S_REQ; new address presented next cycle.
  - S_REQ with handshake in the same cycle: the issued request is stale -> S_WAIT, drop=1.
  - S_WAIT without rsp_valid: stay S_WAIT, drop=1.
  - S_WAIT with rsp_valid in the same cycle: discard data, -> S_REQ, drop=0.
  - S_VALID: -> S_REQ. inst_ready in the same cycle is treated as consumed; pc takes the redirect target, not pc+4.
  - Back-to-back redirects: last one wins; drop never counts above 1 because only one request is outstanding.
- Reset asserted mid-operation: immediate return to reset state.
  - A late response belonging to the pre-reset request arrives while in S_REQ and is ignored.
- No combinational path from imem_rdata to inst; inst is always registered.

Test Plan:
- Reset release, memory always ready, rsp 1 cycle later, inst_ready=1:
  - first imem_addr=0x80000000; inst_valid rises with inst_pc=0x80000000.
  - Next addresses 0x80000004, 0x80000008; one instruction every 3 cycles.
- Decode stall: inst_ready=0 for 5 cycles with inst=0x00100073:
  - inst and inst_pc stable, no new request issued.
  - After inst_ready=1, next imem_addr=inst_pc+4.
- Redirect in S_WAIT to 0x80000100, response arrives 2 cycles later with 0xDEADBEEF:
  - response discarded, inst_valid stays 0.
  - Next request addr=0x80000100.
- Redirect in S_VALID together with inst_ready, target 0x80000020:
  - next imem_addr=0x80000020, not inst_pc+4.
- Redirect to 0x80000022: misalign_err=1 for one cycle; next imem_addr=0x80000020.
- Assert rst while in S_WAIT, then drive imem_rsp_valid after release:
  - response ignored; imem_addr=0x80000000; inst_valid=0 until the fresh response.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one-outstanding reads to instruction memory,
// and holds each returned instruction with its PC until decode takes it.
module ifu_fetch #(
   parameter int unsigned               PC_WIDTH   = 64,
   parameter int unsigned               INST_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]       RESET_PC   = 64'h0000_0000_8000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INST_WIDTH-1:0]  imem_rdata,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [INST_WIDTH-1:0]  inst,
   output logic [PC_WIDTH-1:0]    inst_pc,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   misalign_err
);

   localparam logic [1:0] S_REQ   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_VALID = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic                  drop_q, drop_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [PC_WIDTH-1:0]   inst_pc_q, inst_pc_d;
   logic                  misalign_q, misalign_d;

   // pc stays on the address of the outstanding request; it only advances once decode consumes the instruction.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      misalign_d = 1'b0;

      case (state_q)
         S_REQ: begin
            if (imem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  inst_d    = imem_rdata;
                  inst_pc_d = pc_q;
                  state_d   = S_VALID;
               end
            end
         end
         S_VALID: begin
            if (inst_ready) begin
               pc_d    = pc_q + PC_WIDTH'(4);
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
            drop_d  = 1'b0;
         end
      endcase

      // A redirect overrides everything above; a request already in flight becomes stale and is dropped.
      if (redirect_valid) begin
         pc_d       = {redirect_pc[PC_WIDTH-1:2], 2'b00};
         misalign_d = |redirect_pc[1:0];
         inst_d     = inst_q;
         inst_pc_d  = inst_pc_q;
         case (state_q)
            S_REQ: begin
               if (imem_req_ready) begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = S_REQ;
                  drop_d  = 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  state_d = S_REQ;
                  drop_d  = 1'b0;
               end else begin
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_REQ;
               drop_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_addr      = pc_q;
   assign imem_req_valid = (state_q == S_REQ);
   assign inst_valid     = (state_q == S_VALID);
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed vector table, hand-written corner sequences, and a randomized
// run checked against a program-order model with a behavioural instruction memory.
module tb_ifu_fetch;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   ifu_fetch #(
      .PC_WIDTH   (64),
      .INST_WIDTH (32),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .misalign_err   (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        req_ready;
      logic        rsp_valid;
      logic [31:0] rdata;
      logic        iready;
      logic        redir;
      logic [63:0] redir_pc;
      logic        exp_req;
      logic [63:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_inst;
      logic [63:0] exp_ipc;
      logic        exp_mis;
   } vec_t;

   function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic rdv, input logic [63:0] rpc,
                               input logic eq, input logic [63:0] ea, input logic ev,
                               input logic [31:0] ei, input logic [63:0] ep, input logic em);
      vec_t v;
      v.req_ready = rr;  v.rsp_valid = rv;  v.rdata    = rd;
      v.iready    = ir;  v.redir     = rdv; v.redir_pc = rpc;
      v.exp_req   = eq;  v.exp_addr  = ea;  v.exp_iv   = ev;
      v.exp_inst  = ei;  v.exp_ipc   = ep;  v.exp_mis  = em;
      return v;
   endfunction

   // Behavioural instruction memory contents: any address-dependent scramble will do.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      imem_req_ready = v.req_ready;
      imem_rsp_valid = v.rsp_valid;
      imem_rdata     = v.rdata;
      inst_ready     = v.iready;
      redirect_valid = v.redir;
      redirect_pc    = v.redir_pc;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      checkVal({tag, ".req_valid"}, 64'(imem_req_valid), 64'(v.exp_req));
      checkVal({tag, ".addr"},      imem_addr,           v.exp_addr);
      checkVal({tag, ".inst_valid"},64'(inst_valid),     64'(v.exp_iv));
      checkVal({tag, ".inst"},      64'(inst),           64'(v.exp_inst));
      checkVal({tag, ".inst_pc"},   inst_pc,             v.exp_ipc);
      checkVal({tag, ".misalign"},  64'(misalign_err),   64'(v.exp_mis));
   endtask

   task automatic step(input vec_t v, input string tag);
      applyStimulus(v);
      #1;
      checkOutput(v, tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
      #1;
      checkOutput(mk(0,0,0,0,0,0, 1,RESET_PC,0,32'h0,64'h0,0), "reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t vecs[22];

   initial begin
      logic [63:0] exp_pc;
      logic [63:0] rtarget;
      logic [63:0] out_addr;
      logic        exp_mis;
      bit          outst;
      int          cd;
      int          delivered;

      rst = 1'b0;
      applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
      #2;
      do_reset();

      vecs[0]  = mk(1,0,32'h0,       1,0,64'h0,         1,64'h8000_0000,0,32'h0,       64'h0,         0);
      vecs[1]  = mk(1,1,32'h13,      1,0,64'h0,         0,64'h8000_0000,0,32'h0,       64'h0,         0);
      vecs[2]  = mk(1,0,32'h0,       1,0,64'h0,         0,64'h8000_0000,1,32'h13,      64'h8000_0000, 0);
      vecs[3]  = mk(1,0,32'h0,       1,0,64'h0,         1,64'h8000_0004,0,32'h13,      64'h8000_0000, 0);
      vecs[4]  = mk(1,1,32'h0010_0073,1,0,64'h0,        0,64'h8000_0004,0,32'h13,      64'h8000_0000, 0);
      for (int i = 5; i <= 9; i++)
         vecs[i] = mk(1,0,32'h0,     0,0,64'h0,         0,64'h8000_0004,1,32'h0010_0073,64'h8000_0004,0);
      vecs[10] = mk(1,0,32'h0,       1,0,64'h0,         0,64'h8000_0004,1,32'h0010_0073,64'h8000_0004,0);
      vecs[11] = mk(1,0,32'h0,       1,0,64'h0,         1,64'h8000_0008,0,32'h0010_0073,64'h8000_0004,0);
      vecs[12] = mk(1,0,32'h0,       1,1,64'h8000_0100, 0,64'h8000_0008,0,32'h0010_0073,64'h8000_0004,0);
      vecs[13] = mk(1,0,32'h0,       1,0,64'h0,         0,64'h8000_0100,0,32'h0010_0073,64'h8000_0004,0);
      vecs[14] = mk(1,1,32'hDEAD_BEEF,1,0,64'h0,        0,64'h8000_0100,0,32'h0010_0073,64'h8000_0004,0);
      vecs[15] = mk(1,0,32'h0,       1,0,64'h0,         1,64'h8000_0100,0,32'h0010_0073,64'h8000_0004,0);
      vecs[16] = mk(1,1,32'h1111_1111,1,0,64'h0,        0,64'h8000_0100,0,32'h0010_0073,64'h8000_0004,0);
      vecs[17] = mk(1,0,32'h0,       1,1,64'h8000_0020, 0,64'h8000_0100,1,32'h1111_1111,64'h8000_0100,0);
      vecs[18] = mk(0,0,32'h0,       1,1,64'h8000_0022, 1,64'h8000_0020,0,32'h1111_1111,64'h8000_0100,0);
      vecs[19] = mk(0,0,32'h0,       1,0,64'h0,         1,64'h8000_0020,0,32'h1111_1111,64'h8000_0100,1);
      vecs[20] = mk(1,0,32'h0,       1,0,64'h0,         1,64'h8000_0020,0,32'h1111_1111,64'h8000_0100,0);
      vecs[21] = mk(1,0,32'h0,       1,0,64'h0,         0,64'h8000_0020,0,32'h1111_1111,64'h8000_0100,0);

      for (int i = 0; i < 22; i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // Reset while a request is outstanding; the late response lands in S_REQ and must be ignored.
      do_reset();
      step(mk(0,1,32'hBAD0_BAD0,0,0,64'h0, 1,64'h8000_0000,0,32'h0,64'h0,0), "late_rsp");
      step(mk(1,0,32'h0,        0,0,64'h0, 1,64'h8000_0000,0,32'h0,64'h0,0), "post_rst_req");
      step(mk(0,1,32'h93,       0,0,64'h0, 0,64'h8000_0000,0,32'h0,64'h0,0), "post_rst_rsp");
      step(mk(0,0,32'h0,        0,1,64'hFFFF_FFFF_FFFF_FFFC,
              0,64'h8000_0000,1,32'h93,64'h8000_0000,0), "valid_redir");
      step(mk(1,0,32'h0,        0,0,64'h0, 1,64'hFFFF_FFFF_FFFF_FFFC,0,32'h93,64'h8000_0000,0), "top_req");
      step(mk(0,1,32'h13,       0,0,64'h0, 0,64'hFFFF_FFFF_FFFF_FFFC,0,32'h93,64'h8000_0000,0), "top_rsp");
      step(mk(0,0,32'h0,        1,0,64'h0, 0,64'hFFFF_FFFF_FFFF_FFFC,1,32'h13,64'hFFFF_FFFF_FFFF_FFFC,0), "top_inst");
      step(mk(1,0,32'h0,        0,1,64'h8000_0040,
              1,64'h0,0,32'h13,64'hFFFF_FFFF_FFFF_FFFC,0), "wrap_req_redir");
      step(mk(0,1,32'h7777_7777,0,0,64'h0, 0,64'h8000_0040,0,32'h13,64'hFFFF_FFFF_FFFF_FFFC,0), "stale_rsp");
      step(mk(1,0,32'h0,        0,0,64'h0, 1,64'h8000_0040,0,32'h13,64'hFFFF_FFFF_FFFF_FFFC,0), "refetch_req");
      step(mk(0,1,32'h33,       0,0,64'h0, 0,64'h8000_0040,0,32'h13,64'hFFFF_FFFF_FFFF_FFFC,0), "refetch_rsp");
      step(mk(0,0,32'h0,        0,0,64'h0, 0,64'h8000_0040,1,32'h33,64'h8000_0040,0), "refetch_inst");

      // Randomized run: the model only tracks the program-order PC and what memory holds there.
      do_reset();
      exp_pc    = RESET_PC;
      exp_mis   = 1'b0;
      outst     = 1'b0;
      cd        = 0;
      out_addr  = '0;
      delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         case ($urandom_range(0, 3))
            0:       rtarget = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            default: rtarget = 64'h8000_0000 + 64'($urandom_range(0, 255));
         endcase
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = rtarget;
         imem_req_ready = ($urandom_range(0, 2) != 0);
         inst_ready     = ($urandom_range(0, 2) != 0);
         if (outst && cd == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = mem_word(out_addr);
         end else if (!outst && $urandom_range(0, 5) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = $urandom;
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rdata     = $urandom;
         end
         #1;
         checkVal("rnd_misalign", 64'(misalign_err), 64'(exp_mis));
         if (imem_req_valid)
            checkVal("rnd_one_outstanding", 64'(outst), 64'h0);
         if (imem_req_valid && imem_req_ready && !redirect_valid)
            checkVal("rnd_req_addr", imem_addr, exp_pc);
         if (inst_valid && inst_ready) begin
            checkVal("rnd_inst_pc", inst_pc, exp_pc);
            checkVal("rnd_inst", 64'(inst), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            delivered++;
         end
         if (redirect_valid) begin
            exp_pc  = {rtarget[63:2], 2'b00};
            exp_mis = |rtarget[1:0];
         end else begin
            exp_mis = 1'b0;
         end
         if (outst) begin
            if (imem_rsp_valid) outst = 1'b0;
            else                cd--;
         end else if (imem_req_valid && imem_req_ready) begin
            outst    = 1'b1;
            out_addr = imem_addr;
            cd       = $urandom_range(0, 3);
         end
         @(negedge clk);
      end
      checkVal("rnd_progress", 64'(delivered >= 100), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
